// File: rtl/jt6295_rate_gen.sv
// rtl/jt6295_rate_gen.sv - sample-rate, oversample and channel-slot timing generator
//
// Divides the chip clock enable into a sample strobe (cen_sr), an OVS-times
// oversample strobe (cen_ovs) and a per-channel slot strobe (ch_cen/ch_idx).
// Optional feature macro: JT6295_RATE_DIV_EN (adds a runtime period override port div).
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous reset, active low
//   cen     in   clock enable; all state moves only when cen=1
//   ss      in   rate select: 1 = DIV_HI, 0 = DIV_LO
//   sync    in   restart request, honoured only with cen=1
//   div     in   (JT6295_RATE_DIV_EN only) nonzero overrides the period at latch time
//   cen_sr  out  sample strobe, one clk wide
//   cen_ovs out  oversample strobe, OVS pulses per period
//   ch_cen  out  channel slot strobe
//   ch_idx  out  index of the latest channel slot, held between strobes
//   phase   out  current phase counter
module jt6295_rate_gen #(
  parameter int DW     = 9,
  parameter int DIV_HI = 132,
  parameter int DIV_LO = 165,
  parameter int OVS    = 4,
  parameter int CH     = 4,
  parameter int SLOT   = 8,
  localparam int IW    = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          ss,
  input  logic          sync,
`ifdef JT6295_RATE_DIV_EN
  input  logic [DW-1:0] div,
`endif
  output logic          cen_sr,
  output logic          cen_ovs,
  output logic          ch_cen,
  output logic [IW-1:0] ch_idx,
  output logic [DW-1:0] phase
);

  localparam int            LOG_OVS = $clog2(OVS);
  localparam logic [DW-1:0] N_HI    = DW'(DIV_HI);
  localparam logic [DW-1:0] N_LO    = DW'(DIV_LO);
  localparam logic [DW-1:0] ONE     = DW'(1);
  localparam logic [DW-1:0] ZERO    = '0;
  localparam logic [DW-1:0] OVS_M1  = DW'(OVS - 1);
  localparam logic [DW-1:0] CH_M1   = DW'(CH - 1);
  localparam logic [DW-1:0] SLOT_M1 = DW'(SLOT - 1);

  logic [DW-1:0] ph, n_r, step_r;
  // Distance to the next oversample/slot point and how many points remain
  // in this period; both are reloaded at ph==0 so no divider is needed.
  logic [DW-1:0] ovs_left, ovs_num, slot_left, slot_num;
  logic [DW-1:0] n_sel;
  logic          at_zero, wrap, restart, ovs_hit, slot_hit;

  always_comb begin
    n_sel = ss ? N_HI : N_LO;
`ifdef JT6295_RATE_DIV_EN
    if (div != ZERO) n_sel = div;
`endif
  end

  assign at_zero  = (ph == ZERO);
  // n_r-1 wraps to all ones for a full 2**DW period, which is what we want.
  assign wrap     = (ph == n_r - ONE);
  assign restart  = wrap | sync;
  assign ovs_hit  = at_zero | ((ovs_num  != ZERO) && (ovs_left  == ZERO));
  assign slot_hit = at_zero | ((slot_num != ZERO) && (slot_left == ZERO));
  assign phase    = ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= ZERO;
      n_r       <= N_LO;
      step_r    <= N_LO >> LOG_OVS;
      ovs_left  <= ZERO;
      ovs_num   <= ZERO;
      slot_left <= ZERO;
      slot_num  <= ZERO;
      cen_sr    <= 1'b0;
      cen_ovs   <= 1'b0;
      ch_cen    <= 1'b0;
      ch_idx    <= '0;
    end else begin
      cen_sr  <= 1'b0;
      cen_ovs <= 1'b0;
      ch_cen  <= 1'b0;
      if (cen) begin
        // Strobes and point counters follow the pre-increment phase,
        // including on a sync cycle.
        cen_sr  <= at_zero;
        cen_ovs <= ovs_hit;
        ch_cen  <= slot_hit;

        if (at_zero) begin
          ovs_left <= step_r - ONE;
          ovs_num  <= OVS_M1;
        end else if (ovs_hit) begin
          ovs_left <= step_r - ONE;
          ovs_num  <= ovs_num - ONE;
        end else begin
          ovs_left <= ovs_left - ONE;
        end

        if (at_zero) begin
          slot_left <= SLOT_M1;
          slot_num  <= CH_M1;
          ch_idx    <= '0;
        end else if (slot_hit) begin
          slot_left <= SLOT_M1;
          slot_num  <= slot_num - ONE;
          ch_idx    <= ch_idx + IW'(1);
        end else begin
          slot_left <= slot_left - ONE;
        end

        // Period and step only change when the phase restarts, so a
        // running period is never disturbed by ss/div changes.
        if (restart) begin
          ph     <= ZERO;
          n_r    <= n_sel;
          step_r <= n_sel >> LOG_OVS;
        end else begin
          ph <= ph + ONE;
        end
      end
    end
  end

endmodule
